simon_engine: RTL and testbench

Parametrised, single-clock Simon game engine. It absorbs the LFSR, sequence store, loader and game FSM into one block, generalised to CHANNELS buttons/LEDs and DEPTH steps. It adds a growing-round mode, an input timeout and a win indication. It sits between the button inputs and the LED outputs and runs on the board clock, with game pacing set by a one-cycle `tick` enable from the clock divider.

---
 rtl/simon_engine.sv | 187 ++++++++++++++++++
 tb/tb_simon_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_engine.sv
// Simon game engine: free-running LFSR, sequence store, playback and input-checking FSM.
// Fixed or growing-round play, per-press timeout, registered LED/status outputs.
module simon_engine #(
    parameter int          CHANNELS      = 4,
    parameter int          DEPTH         = 16,
    parameter int          TICKS_ON      = 4,
    parameter int          TICKS_GAP     = 2,
    parameter int          TIMEOUT_TICKS = 40,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         start,
    input  logic                         mode,
    input  logic [CHANNELS-1:0]          btn,
    output logic [CHANNELS-1:0]          led,
    output logic                         error_led,
    output logic                         win,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int          CW       = $clog2(CHANNELS);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          LW       = $clog2(DEPTH + 1);
    localparam int          TMAX     = (TICKS_ON > TICKS_GAP) ? TICKS_ON : TICKS_GAP;
    localparam int          TW       = $clog2(TMAX + 1);
    localparam int          OW       = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GAP, S_SHOW, S_INPUT, S_RELEASE, S_WIN, S_FAIL
    } state_t;

    state_t                state;
    logic [15:0]           lfsr;
    logic [CW-1:0]         seq [DEPTH];
    logic [LW-1:0]         idx;
    logic [TW-1:0]         tcnt;
    logic [OW-1:0]         tocnt;
    logic [CHANNELS-1:0]   btn_q;
    logic                  mode_q;

    logic [CW-1:0]         cur_step;
    logic [CHANNELS-1:0]   cur_led;
    logic [LW-1:0]         next_idx;
    logic                  press;

    assign cur_step = seq[idx[AW-1:0]];
    assign cur_led  = CHANNELS'(1) << cur_step;
    assign next_idx = idx + LW'(1);
    // A press is the all-zero to non-zero edge, so a button already held on entry is ignored.
    assign press    = (btn_q == '0) && (btn != '0);

    // Taps 16,14,13,11; runs every cycle so the sequence depends on when start arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // NOTE: the sequence store has no reset; LOAD always rewrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            seq[idx[AW-1:0]] <= lfsr[CW-1:0];
        end
    end

    // NOTE: led is driven from this register (btn is echoed a cycle late) so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            tcnt      <= '0;
            tocnt     <= '0;
            btn_q     <= '0;
            mode_q    <= 1'b0;
            led       <= '0;
            error_led <= 1'b0;
            win       <= 1'b0;
            busy      <= 1'b0;
            level     <= '0;
        end else begin
            btn_q <= btn;
            case (state)
                S_IDLE, S_WIN, S_FAIL: begin
                    if (start) begin
                        state     <= S_LOAD;
                        mode_q    <= mode;
                        level     <= mode ? LW'(1) : LW'(DEPTH);
                        idx       <= '0;
                        tcnt      <= '0;
                        tocnt     <= '0;
                        led       <= '0;
                        error_led <= 1'b0;
                        win       <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (idx == LW'(DEPTH - 1)) begin
                        idx   <= '0;
                        tcnt  <= '0;
                        state <= S_GAP;
                    end else begin
                        idx <= next_idx;
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (tcnt == TW'(TICKS_GAP - 1)) begin
                            tcnt <= '0;
                            if (idx < level) begin
                                state <= S_SHOW;
                                led   <= cur_led;
                            end else begin
                                state <= S_INPUT;
                                idx   <= '0;
                                tocnt <= '0;
                            end
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                S_SHOW: begin
                    if (tick) begin
                        if (tcnt == TW'(TICKS_ON - 1)) begin
                            tcnt  <= '0;
                            idx   <= next_idx;
                            led   <= '0;
                            state <= S_GAP;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                S_INPUT: begin
                    led <= btn;
                    // A press in the same cycle as the final timeout tick still wins.
                    if (press) begin
                        if (btn == cur_led) begin
                            state <= S_RELEASE;
                            tocnt <= '0;
                        end else begin
                            state     <= S_FAIL;
                            error_led <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end else if (tick) begin
                        if (tocnt == OW'(TIMEOUT_TICKS - 1)) begin
                            state     <= S_FAIL;
                            error_led <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            tocnt <= tocnt + OW'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    led <= btn;
                    if (btn == '0) begin
                        if (next_idx < level) begin
                            idx   <= next_idx;
                            state <= S_INPUT;
                        end else if (mode_q && (level < LW'(DEPTH))) begin
                            level <= level + LW'(1);
                            idx   <= '0;
                            tcnt  <= '0;
                            state <= S_GAP;
                        end else begin
                            idx   <= next_idx;
                            state <= S_WIN;
                            win   <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_engine.sv
// Directed bench for simon_engine (4 channels, depth 4): reset, fixed/growing wins,
// wrong and multi-button presses, timeout with press priority, restart and start-ignore.
module tb_simon_engine;

    localparam int TON = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] led;
    logic       error_led;
    logic       win;
    logic       busy;
    logic [2:0] level;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  exp_seq [4];
    logic [3:0]  seen [4];

    simon_engine #(
        .CHANNELS(4), .DEPTH(4), .TICKS_ON(TON), .TICKS_GAP(1),
        .TIMEOUT_TICKS(8), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .mode(mode),
        .btn(btn), .led(led), .error_led(error_led), .win(win), .busy(busy),
        .level(level)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, advancing every cycle out of reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [3:0] onehot4(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_clear(input string tag);
        tests++;
        if ({led, error_led, win, busy, level} !== 10'b0) begin
            $display("FAIL %s: led=%b err=%b win=%b busy=%b level=%0d, required all 0",
                     tag, led, error_led, win, busy, level);
            fails++;
        end
    endtask

    // Request a game; record the LFSR value the DUT writes at each LOAD cycle.
    task automatic start_game(input logic m, input logic [2:0] exp_level);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
        tests++;
        if ({busy, error_led, win, led, level} !== {1'b1, 1'b0, 1'b0, 4'b0000, exp_level}) begin
            $display("FAIL start: busy=%b err=%b win=%b led=%b level=%0d, required 1 0 0 0000 %0d",
                     busy, error_led, win, led, level, exp_level);
            fails++;
        end
        exp_seq[0] = m_lfsr[1:0];
        for (int a = 1; a < 4; a++) begin
            step();
            exp_seq[a] = m_lfsr[1:0];
        end
    endtask

    // Capture n playback pulses, checking each length; returns one cycle into INPUT.
    task automatic capture(input int n, input bit poke);
        int got;
        int len;
        int budget;
        got = 0; len = 0; budget = 0;
        while (got < n && budget < 400) begin
            step();
            budget++;
            if (led != 4'b0000) begin
                if (len == 0) seen[got] = led;
                len++;
                start = (poke && got == 0 && len == 1);
            end else if (len != 0) begin
                tests++;
                if (len !== TON) begin
                    $display("FAIL pulse_len[%0d]: got %0d cycles, required %0d", got, len, TON);
                    fails++;
                end
                got++;
                len = 0;
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (got < n) begin
            tests++;
            fails++;
            $display("FAIL capture_timeout: saw %0d pulses, required %0d", got, n);
        end
        step();
    endtask

    task automatic check_seen(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tests++;
            if (seen[i] !== onehot4(exp_seq[i])) begin
                $display("FAIL %s step %0d: led=%b, required %b", tag, i, seen[i], onehot4(exp_seq[i]));
                fails++;
            end
        end
    endtask

    task automatic reply(input int n);
        for (int i = 0; i < n; i++) begin
            btn = seen[i];
            step();
            tests++;
            if (led !== seen[i]) begin
                $display("FAIL echo %0d: led=%b, required %b", i, led, seen[i]);
                fails++;
            end
            btn = 4'b0000;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        check_outputs_clear("reset_state");
        reset = 1'b1;
        step();
        step();
        check_outputs_clear("idle_hold");
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1;
        mode  = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check_outputs_clear("reset_mid_load");
        #2;
        reset = 1'b1;
        step();
        check_outputs_clear("idle_after_reset");
    endtask

    task automatic test_fixed_win();
        start_game(1'b0, 3'd4);
        capture(4, 1'b0);
        check_seen(4, "fixed_play");
        reply(4);
        tests++;
        if ({win, busy, error_led, level} !== {1'b1, 1'b0, 1'b0, 3'd4}) begin
            $display("FAIL fixed_win: win=%b busy=%b err=%b level=%0d, required 1 0 0 4",
                     win, busy, error_led, level);
            fails++;
        end
    endtask

    task automatic test_growing_win();
        start_game(1'b1, 3'd1);
        for (int r = 1; r <= 4; r++) begin
            tests++;
            if (level !== 3'(r)) begin
                $display("FAIL grow_level: level=%0d, required %0d", level, r);
                fails++;
            end
            capture(r, 1'b0);
            check_seen(r, "grow_play");
            for (int k = 0; k < 3; k++) begin
                step();
                tests++;
                if (led !== 4'b0000) begin
                    $display("FAIL grow_extra_pulse round %0d: led=%b, required 0000", r, led);
                    fails++;
                end
            end
            reply(r);
            tests++;
            if (win !== (r == 4)) begin
                $display("FAIL grow_win round %0d: win=%b, required %b", r, win, (r == 4));
                fails++;
            end
        end
        tests++;
        if ({busy, error_led, level} !== {1'b0, 1'b0, 3'd4}) begin
            $display("FAIL grow_final: busy=%b err=%b level=%0d, required 0 0 4", busy, error_led, level);
            fails++;
        end
    endtask

    task automatic test_wrong_press();
        logic [3:0] wrong;
        start_game(1'b0, 3'd4);
        capture(4, 1'b0);
        wrong = {seen[0][2:0], seen[0][3]};
        btn = wrong;
        step();
        tests++;
        if ({error_led, busy, win} !== 3'b100) begin
            $display("FAIL wrong_press: err=%b busy=%b win=%b, required 1 0 0", error_led, busy, win);
            fails++;
        end
        btn = 4'b0000;
        step();
        start_game(1'b0, 3'd4);
        capture(4, 1'b0);
        btn = 4'b0011;
        step();
        tests++;
        if ({error_led, busy, win} !== 3'b100) begin
            $display("FAIL multi_press: err=%b busy=%b win=%b, required 1 0 0", error_led, busy, win);
            fails++;
        end
        btn = 4'b0000;
        step();
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic test_timeout();
        start_game(1'b0, 3'd4);
        capture(4, 1'b0);
        tick = 1'b0;
        pulse_ticks(7);
        tests++;
        if (error_led !== 1'b0) begin
            $display("FAIL timeout_early: err=%b after 7 ticks, required 0", error_led);
            fails++;
        end
        btn  = seen[0];
        tick = 1'b1;
        step();
        tick = 1'b0;
        tests++;
        if ({error_led, led} !== {1'b0, seen[0]}) begin
            $display("FAIL press_priority: err=%b led=%b, required 0 %b", error_led, led, seen[0]);
            fails++;
        end
        btn = 4'b0000;
        step();
        pulse_ticks(7);
        tests++;
        if (error_led !== 1'b0) begin
            $display("FAIL timeout_restart: err=%b after 7 ticks, required 0", error_led);
            fails++;
        end
        pulse_ticks(1);
        tests++;
        if ({error_led, busy} !== 2'b10) begin
            $display("FAIL timeout_fire: err=%b busy=%b after 8 ticks, required 1 0", error_led, busy);
            fails++;
        end
        tick = 1'b1;
    endtask

    task automatic test_restart_ignore();
        start_game(1'b0, 3'd4);
        capture(4, 1'b1);
        check_seen(4, "ignore_play");
        tests++;
        if (busy !== 1'b1) begin
            $display("FAIL ignore_busy: busy=%b, required 1", busy);
            fails++;
        end
        reply(4);
        tests++;
        if ({win, error_led} !== 2'b10) begin
            $display("FAIL ignore_win: win=%b err=%b, required 1 0", win, error_led);
            fails++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_load();
        test_fixed_win();
        test_growing_win();
        test_wrong_press();
        test_timeout();
        test_restart_ignore();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
